// File: rtl/sd_pcm_stream_buffer_pkg.sv
// sd_pcm_stream_buffer_pkg: shared encodings and helpers for the PCM stream buffer
package sd_pcm_stream_buffer_pkg;
    localparam int BLOCK_BYTES = 512;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_FILL} w_state_t;
    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_t;
    function automatic logic [31:0] next_block(input logic [31:0] a, input logic [31:0] s, input logic [31:0] e);
        return (a == e) ? s : a + 32'd1;
    endfunction
endpackage

// File: rtl/sd_pcm_stream_buffer_if.sv
// sd_pcm_stream_buffer_if: request/data handshake between the buffer (master) and the SD block reader (slave)
interface sd_pcm_stream_buffer_if;
    logic        sd_card_ready;
    logic        sd_read_block;
    logic        sd_cont_read;
    logic [31:0] sd_block_addr;
    logic [7:0]  sd_data;
    logic [11:0] sd_data_idx;
    logic        sd_data_rdy;
    modport master(output sd_read_block, sd_cont_read, sd_block_addr,
                   input sd_card_ready, sd_data, sd_data_idx, sd_data_rdy);
    modport slave(input sd_read_block, sd_cont_read, sd_block_addr,
                  output sd_card_ready, sd_data, sd_data_idx, sd_data_rdy);
endinterface

// File: rtl/sd_pingpong_ram.sv
// sd_pingpong_ram: 2 x 512 B simple dual-port RAM, sync write, 1-cycle sync read
module sd_pingpong_ram
    import sd_pcm_stream_buffer_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [9:0] wa,
    input  logic [7:0] wd,
    input  logic [9:0] ra,
    output logic [7:0] rd
);
    logic [7:0] mem [2*BLOCK_BYTES];
    // write port A, registered read port B
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end
endmodule

// File: rtl/sd_pcm_stream_buffer.sv
// sd_pcm_stream_buffer: prefetches SD blocks into a ping-pong buffer and drains them as 16-bit PCM
module sd_pcm_stream_buffer
    import sd_pcm_stream_buffer_pkg::*;
#(
    parameter logic [31:0] START_BLOCK = 32'd0,
    parameter logic [31:0] END_BLOCK   = 32'd1023
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         sample_tick,
    sd_pcm_stream_buffer_if.master       sd,
    output logic [15:0]                  sample_out,
    output logic                         sample_valid,
    output logic                         underrun,
    output logic [7:0]                   retry_cnt
);
    w_state_t w_state, w_next;
    bank_st_t bank [2];
    logic fill_bank, play_bank, got_last, w_start, w_done, last_now, blk_ok, r_free;
    logic [7:0] rd_ptr, lo_q, rd_data;
    logic [1:0] stage;
    assign sd.sd_cont_read = 1'b0;
    assign last_now = sd.sd_data_rdy && sd.sd_data_idx == 12'(BLOCK_BYTES - 1);
    assign blk_ok = got_last || last_now;
    assign r_free = stage == 2'd2 && rd_ptr == 8'hff;
    sd_pingpong_ram u_ram (
        .clk(clk),
        .we(w_state == W_FILL && sd.sd_data_rdy),
        .wa({fill_bank, sd.sd_data_idx[8:0]}),
        .wd(sd.sd_data),
        .ra({play_bank, rd_ptr, stage == 2'd1}),
        .rd(rd_data)
    );
    // writer state register
    always_ff @(posedge clk) begin
        if (!rst_n) w_state <= W_IDLE;
        else w_state <= w_next;
    end
    // writer next state: request, wait for acceptance, fill until reader idles again
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (enable && bank[fill_bank] == B_EMPTY && sd.sd_card_ready) w_next = W_WAIT;
            W_WAIT: if (!sd.sd_card_ready) w_next = W_FILL;
            W_FILL: if (sd.sd_card_ready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end
    // writer outputs: one-cycle request strobe and block-end event
    always_comb begin
        w_start = rst_n && w_state == W_IDLE && w_next == W_WAIT;
        w_done = w_state == W_FILL && sd.sd_card_ready;
        sd.sd_read_block = w_start;
    end
    // bank ownership: writer claims/publishes its bank, reader releases a drained one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank[0] <= B_EMPTY;
            bank[1] <= B_EMPTY;
        end else begin
            if (w_start) bank[fill_bank] <= B_FILLING;
            if (w_done) bank[fill_bank] <= blk_ok ? B_FULL : B_EMPTY;
            if (r_free) bank[play_bank] <= B_EMPTY;
        end
    end
    // writer datapath: last-byte tracking, address advance or retry on a short block
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_bank <= 1'b0;
            sd.sd_block_addr <= START_BLOCK;
            retry_cnt <= 8'd0;
            got_last <= 1'b0;
        end else begin
            if (w_start) got_last <= 1'b0;
            else if (w_state == W_FILL && last_now) got_last <= 1'b1;
            if (w_done && blk_ok) begin
                fill_bank <= ~fill_bank;
                sd.sd_block_addr <= next_block(sd.sd_block_addr, START_BLOCK, END_BLOCK);
            end else if (w_done && retry_cnt != 8'hff) retry_cnt <= retry_cnt + 8'd1;
        end
    end
    // reader: lo byte addressed on the tick cycle, hi byte next, sample 3 cycles after tick; rd_ptr counts words
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage <= 2'd0;
            rd_ptr <= 8'd0;
            play_bank <= 1'b0;
            lo_q <= 8'd0;
            sample_out <= 16'd0;
            sample_valid <= 1'b0;
            underrun <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            underrun <= 1'b0;
            if (stage == 2'd0 && sample_tick && enable) begin
                if (bank[play_bank] == B_FULL) stage <= 2'd1;
                else begin
                    underrun <= 1'b1;
                    sample_out <= 16'd0;
                    sample_valid <= 1'b1;
                end
            end
            if (stage == 2'd1) begin
                lo_q <= rd_data;
                stage <= 2'd2;
            end
            if (stage == 2'd2) begin
                sample_out <= {rd_data, lo_q};
                sample_valid <= 1'b1;
                rd_ptr <= rd_ptr + 8'd1;
                stage <= 2'd0;
                if (r_free) play_bank <= ~play_bank;
            end
        end
    end
endmodule
